id_ex_stage: RTL and testbench
==============================

Name: id_ex_stage

Overview:
- Decode-to-execute pipeline boundary of the pipelined CPU, directly downstream of the instruction/ALU decoder.
- Registers the decoder's control word, the register-file operands and the extended immediate into the E stage.
- Detects load-use hazards and produces the stall and bubble controls, plus the EX-stage operand forwarding selects.
- Holds the architectural NZCV flags register, written when a flag-setting instruction (CMP) executes.

Parameters:
- WIDTH, 32, datapath width of operands and immediate.
- RADDR, 4, register address width.

Ports:
- clk  in  1  system clock, all state updates on rising edge.
- rst  in  1  asynchronous, active-low reset.
- reg_write_d  in  1  decoder RegWrite.
- mem_to_reg_d  in  1  decoder MemtoReg.
- mem_write_d  in  1  decoder MemWrite.
- alu_src_d  in  1  decoder ALUSrc.
- flags_write_d  in  1  decoder FlagsWrite.
- alu_control_d  in  3  decoder ALUControl.
- rd1_d, rd2_d  in  WIDTH  register-file read data.
- ext_imm_d  in  WIDTH  extended immediate.
- ra1_d, ra2_d  in  RADDR  source register addresses in D.
- wa3_d  in  RADDR  destination register address in D.
- flush_e  in  1  external flush (taken branch) of the instruction entering E.
- wa3_m, wa3_w  in  RADDR  destination addresses in M and W.
- reg_write_m, reg_write_w  in  1  write enables in M and W.
- alu_flags_e  in  4  NZCV produced by the ALU in E.
- Registered E-stage copies: reg_write_e, mem_to_reg_e, mem_write_e, alu_src_e, flags_write_e (1 bit each), alu_control_e (3), rd1_e, rd2_e, ext_imm_e (WIDTH), ra1_e, ra2_e, wa3_e (RADDR). All outputs.
- valid_e  out  1  E holds a real instruction, not a bubble.
- flags  out  4  architectural NZCV register.
- fwd_a_e, fwd_b_e  out  2  operand forward selects: 00 register file, 01 from W, 10 from M.
- stall_f, stall_d  out  1  hold the PC and the IF/ID register.

Behaviour:
- Reset (rst=0, asynchronous) clears every registered output, valid_e and flags to 0.
- Load-use hazard: ldr_stall = valid_e & mem_to_reg_e & ((ra1_d==wa3_e) | (ra2_d==wa3_e)).
  - Both address compares are always made, regardless of operand use; a spurious stall is allowed.
  - stall_f = stall_d = ldr_stall. These are combinational from the current E state and D inputs.
- Register update on each clock edge, in priority order:
  1. flush_e=1 or ldr_stall=1: insert a bubble. All E fields load 0 and valid_e=0, so reg_write_e, mem_write_e and flags_write_e are 0.
  2. Otherwise: every *_d input loads into its *_e output and valid_e=1.
- A bubble lasts exactly one cycle per stall event. On the next edge the held D instruction loads normally unless a hazard persists.
- The latency from D to E is 1 cycle.
- Forwarding is combinational from the registered E state:
  - fwd_a_e = 10 if reg_write_m & (ra1_e==wa3_m).
  - else fwd_a_e = 01 if reg_write_w & (ra1_e==wa3_w).
  - else fwd_a_e = 00.
  - fwd_b_e uses the same rule with ra2_e.
  - M has priority over W. Register 0 gets no special treatment.
  - When valid_e=0, fwd_a_e and fwd_b_e are forced to 00.
- Flags register: on each edge, if valid_e & flags_write_e then flags <= alu_flags_e, otherwise it holds.
  - The new flags are visible the cycle after the CMP executes.
  - A bubble or a flushed instruction never writes flags.
- Simultaneous flush_e and ldr_stall: the bubble is inserted and stall_f/stall_d still assert. The external PC logic resolves the priority between flush and stall.
- Reset asserted mid-stall: all outputs return to 0 immediately. stall_f and stall_d are 0 while reset is held, because valid_e=0.
- No state other than the E register set and the flags register.

Test Plan:
- Reset: drive random inputs, pulse rst=0 -> all *_e=0, valid_e=0, flags=0000, stall_f=0 during and after reset.
- Normal pass: ADD with rd1_d=0x5, rd2_d=0x7, wa3_d=3, alu_control_d=000, reg_write_d=1 -> next cycle rd1_e=0x5, rd2_e=0x7, wa3_e=3, valid_e=1, stall_f=0.
- Load-use: LDR with wa3_d=2 and mem_to_reg_d=1, then ADD with ra1_d=2:
  - Cycle 2: stall_f=stall_d=1.
  - Cycle 3: valid_e=0 and reg_write_e=0.
  - Cycle 4: the ADD appears in E with valid_e=1 and stall deasserted.
- Forwarding priority: ra1_e=4, wa3_m=4, reg_write_m=1, wa3_w=4, reg_write_w=1 -> fwd_a_e=10. Drop reg_write_m -> fwd_a_e=01. ra2_e=5 with no match -> fwd_b_e=00.
- Flags: CMP in E with flags_write_e=1 and alu_flags_e=0110 -> flags=0110 the next cycle. Then a flushed CMP with alu_flags_e=1000 -> flags stays 0110.
- Flush during hazard: flush_e=1 and ldr_stall=1 in the same cycle -> bubble loaded (valid_e=0), stall_f=1 for that cycle, flags unchanged.

Source files
------------

// File: rtl/id_ex_stage.sv
// Decode-to-execute pipeline register with load-use hazard detection,
// EX operand forwarding selects and the architectural NZCV flags register.
module id_ex_stage #(
  parameter int WIDTH = 32,
  parameter int RADDR = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             reg_write_d,
  input  logic             mem_to_reg_d,
  input  logic             mem_write_d,
  input  logic             alu_src_d,
  input  logic             flags_write_d,
  input  logic [2:0]       alu_control_d,
  input  logic [WIDTH-1:0] rd1_d,
  input  logic [WIDTH-1:0] rd2_d,
  input  logic [WIDTH-1:0] ext_imm_d,
  input  logic [RADDR-1:0] ra1_d,
  input  logic [RADDR-1:0] ra2_d,
  input  logic [RADDR-1:0] wa3_d,
  input  logic             flush_e,
  input  logic [RADDR-1:0] wa3_m,
  input  logic [RADDR-1:0] wa3_w,
  input  logic             reg_write_m,
  input  logic             reg_write_w,
  input  logic [3:0]       alu_flags_e,
  output logic             reg_write_e,
  output logic             mem_to_reg_e,
  output logic             mem_write_e,
  output logic             alu_src_e,
  output logic             flags_write_e,
  output logic [2:0]       alu_control_e,
  output logic [WIDTH-1:0] rd1_e,
  output logic [WIDTH-1:0] rd2_e,
  output logic [WIDTH-1:0] ext_imm_e,
  output logic [RADDR-1:0] ra1_e,
  output logic [RADDR-1:0] ra2_e,
  output logic [RADDR-1:0] wa3_e,
  output logic             valid_e,
  output logic [3:0]       flags,
  output logic [1:0]       fwd_a_e,
  output logic [1:0]       fwd_b_e,
  output logic             stall_f,
  output logic             stall_d
);

  typedef struct packed {
    logic             valid;
    logic             reg_write;
    logic             mem_to_reg;
    logic             mem_write;
    logic             alu_src;
    logic             flags_write;
    logic [2:0]       alu_control;
    logic [WIDTH-1:0] rd1;
    logic [WIDTH-1:0] rd2;
    logic [WIDTH-1:0] ext_imm;
    logic [RADDR-1:0] ra1;
    logic [RADDR-1:0] ra2;
    logic [RADDR-1:0] wa3;
  } e_reg_t;

  e_reg_t     e_q, e_d;
  logic [3:0] flags_q, flags_d;
  logic       ldr_stall;
  logic       bubble;

  function automatic logic [1:0] fwd_sel(
    input logic             vld,
    input logic [RADDR-1:0] ra,
    input logic [RADDR-1:0] wm,
    input logic             we_m,
    input logic [RADDR-1:0] ww,
    input logic             we_w
  );
    logic [1:0] sel;
    sel = 2'b00;
    if (vld) begin
      if (we_m && (ra == wm))      sel = 2'b10;
      else if (we_w && (ra == ww)) sel = 2'b01;
    end
    return sel;
  endfunction

  // Spurious stalls are tolerated: both sources are compared even if unused.
  assign ldr_stall = e_q.valid & e_q.mem_to_reg &
                     ((ra1_d == e_q.wa3) | (ra2_d == e_q.wa3));
  assign bubble    = flush_e | ldr_stall;

  always_comb begin
    e_d = '0;
    if (!bubble) begin
      e_d.valid       = 1'b1;
      e_d.reg_write   = reg_write_d;
      e_d.mem_to_reg  = mem_to_reg_d;
      e_d.mem_write   = mem_write_d;
      e_d.alu_src     = alu_src_d;
      e_d.flags_write = flags_write_d;
      e_d.alu_control = alu_control_d;
      e_d.rd1         = rd1_d;
      e_d.rd2         = rd2_d;
      e_d.ext_imm     = ext_imm_d;
      e_d.ra1         = ra1_d;
      e_d.ra2         = ra2_d;
      e_d.wa3         = wa3_d;
    end
  end

  always_comb begin
    flags_d = flags_q;
    if (e_q.valid && e_q.flags_write) flags_d = alu_flags_e;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      e_q     <= '0;
      flags_q <= '0;
    end else begin
      e_q     <= e_d;
      flags_q <= flags_d;
    end
  end

  assign reg_write_e   = e_q.reg_write;
  assign mem_to_reg_e  = e_q.mem_to_reg;
  assign mem_write_e   = e_q.mem_write;
  assign alu_src_e     = e_q.alu_src;
  assign flags_write_e = e_q.flags_write;
  assign alu_control_e = e_q.alu_control;
  assign rd1_e         = e_q.rd1;
  assign rd2_e         = e_q.rd2;
  assign ext_imm_e     = e_q.ext_imm;
  assign ra1_e         = e_q.ra1;
  assign ra2_e         = e_q.ra2;
  assign wa3_e         = e_q.wa3;
  assign valid_e       = e_q.valid;
  assign flags         = flags_q;
  assign stall_f       = ldr_stall;
  assign stall_d       = ldr_stall;
  assign fwd_a_e = fwd_sel(e_q.valid, e_q.ra1, wa3_m, reg_write_m, wa3_w, reg_write_w);
  assign fwd_b_e = fwd_sel(e_q.valid, e_q.ra2, wa3_m, reg_write_m, wa3_w, reg_write_w);

endmodule

// File: tb/tb_id_ex_stage.sv
// Directed scoreboard bench for id_ex_stage: the driver queues the expected
// per-cycle view, the monitor pops and compares it mid-cycle.
module tb_id_ex_stage;

  typedef struct packed {
    logic        rw, mtr, mw, as, fw;
    logic [2:0]  ctl;
    logic [31:0] rd1, rd2, imm;
    logic [3:0]  ra1, ra2, wa3;
  } dec_t;

  typedef struct packed {
    logic valid;
    dec_t d;
  } e_t;

  typedef struct packed {
    e_t         e;
    logic [3:0] flags;
    logic [1:0] fa, fb;
    logic       stall;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst;
  logic        reg_write_d, mem_to_reg_d, mem_write_d, alu_src_d, flags_write_d;
  logic [2:0]  alu_control_d;
  logic [31:0] rd1_d, rd2_d, ext_imm_d;
  logic [3:0]  ra1_d, ra2_d, wa3_d;
  logic        flush_e;
  logic [3:0]  wa3_m, wa3_w;
  logic        reg_write_m, reg_write_w;
  logic [3:0]  alu_flags_e;
  logic        reg_write_e, mem_to_reg_e, mem_write_e, alu_src_e, flags_write_e;
  logic [2:0]  alu_control_e;
  logic [31:0] rd1_e, rd2_e, ext_imm_e;
  logic [3:0]  ra1_e, ra2_e, wa3_e;
  logic        valid_e;
  logic [3:0]  flags;
  logic [1:0]  fwd_a_e, fwd_b_e;
  logic        stall_f, stall_d;

  int   n_checks = 0;
  int   n_fail   = 0;
  int   cyc      = 0;
  exp_t sb_q[$];

  id_ex_stage #(.WIDTH(32), .RADDR(4)) dut (
    .clk(clk), .rst(rst),
    .reg_write_d(reg_write_d), .mem_to_reg_d(mem_to_reg_d), .mem_write_d(mem_write_d),
    .alu_src_d(alu_src_d), .flags_write_d(flags_write_d), .alu_control_d(alu_control_d),
    .rd1_d(rd1_d), .rd2_d(rd2_d), .ext_imm_d(ext_imm_d),
    .ra1_d(ra1_d), .ra2_d(ra2_d), .wa3_d(wa3_d),
    .flush_e(flush_e), .wa3_m(wa3_m), .wa3_w(wa3_w),
    .reg_write_m(reg_write_m), .reg_write_w(reg_write_w), .alu_flags_e(alu_flags_e),
    .reg_write_e(reg_write_e), .mem_to_reg_e(mem_to_reg_e), .mem_write_e(mem_write_e),
    .alu_src_e(alu_src_e), .flags_write_e(flags_write_e), .alu_control_e(alu_control_e),
    .rd1_e(rd1_e), .rd2_e(rd2_e), .ext_imm_e(ext_imm_e),
    .ra1_e(ra1_e), .ra2_e(ra2_e), .wa3_e(wa3_e),
    .valid_e(valid_e), .flags(flags), .fwd_a_e(fwd_a_e), .fwd_b_e(fwd_b_e),
    .stall_f(stall_f), .stall_d(stall_d)
  );

  always #5 clk = ~clk;

  function automatic dec_t mk(input logic rw, mtr, mw, as, fw, input logic [2:0] ctl,
                              input logic [31:0] rd1, rd2, imm,
                              input logic [3:0] ra1, ra2, wa3);
    return '{rw:rw, mtr:mtr, mw:mw, as:as, fw:fw, ctl:ctl, rd1:rd1, rd2:rd2,
             imm:imm, ra1:ra1, ra2:ra2, wa3:wa3};
  endfunction

  function automatic dec_t rnd_dec();
    dec_t d;
    d = {$urandom, $urandom, $urandom, $urandom};
    return d;
  endfunction

  function automatic e_t ld(input dec_t d);
    return '{valid:1'b1, d:d};
  endfunction

  function automatic exp_t ex(input e_t e, input logic [3:0] f, input logic [1:0] fa, fb,
                              input logic st);
    return '{e:e, flags:f, fa:fa, fb:fb, stall:st};
  endfunction

  task automatic step(input logic rst_v, input dec_t d, input logic fl,
                      input logic [3:0] wm, input logic rwm, input logic [3:0] ww,
                      input logic rww, input logic [3:0] af, input exp_t x);
    rst = rst_v;
    {reg_write_d, mem_to_reg_d, mem_write_d, alu_src_d, flags_write_d} =
      {d.rw, d.mtr, d.mw, d.as, d.fw};
    alu_control_d = d.ctl;
    rd1_d = d.rd1; rd2_d = d.rd2; ext_imm_d = d.imm;
    ra1_d = d.ra1; ra2_d = d.ra2; wa3_d = d.wa3;
    flush_e = fl;
    wa3_m = wm; reg_write_m = rwm; wa3_w = ww; reg_write_w = rww;
    alu_flags_e = af;
    sb_q.push_back(x);
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s cycle %0d: got %h required %h", name, cyc, act, req);
    end
  endtask

  // Monitor: one expected view per cycle, sampled at the falling edge.
  initial begin
    exp_t x;
    e_t   a;
    forever begin
      @(negedge clk);
      if (sb_q.size() > 0) begin
        x = sb_q.pop_front();
        a = '{valid:valid_e, d:'{rw:reg_write_e, mtr:mem_to_reg_e, mw:mem_write_e,
              as:alu_src_e, fw:flags_write_e, ctl:alu_control_e, rd1:rd1_e, rd2:rd2_e,
              imm:ext_imm_e, ra1:ra1_e, ra2:ra2_e, wa3:wa3_e}};
        chk("e_regs",  128'(a),       128'(x.e));
        chk("flags",   128'(flags),   128'(x.flags));
        chk("fwd_a_e", 128'(fwd_a_e), 128'(x.fa));
        chk("fwd_b_e", 128'(fwd_b_e), 128'(x.fb));
        chk("stall_f", 128'(stall_f), 128'(x.stall));
        chk("stall_d", 128'(stall_d), 128'(x.stall));
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete, got timeout required finish");
    $fatal(1);
  end

  initial begin
    dec_t ADD, LDR, ADD2, X, Y, Z, L2, V, L3, U;
    e_t   E0;
    int   wait_cyc;
    E0   = '0;
    ADD  = mk(1,0,0,0,0,3'b000, 32'h5,   32'h7,   32'h0,  4'd1, 4'd2, 4'd3);
    LDR  = mk(1,1,0,1,0,3'b000, 32'h0,   32'h0,   32'h4,  4'd5, 4'd6, 4'd2);
    ADD2 = mk(1,0,0,0,0,3'b000, 32'h11,  32'h22,  32'h0,  4'd2, 4'd7, 4'd4);
    X    = mk(1,0,0,0,0,3'b010, 32'h100, 32'h200, 32'h0,  4'd4, 4'd5, 4'd6);
    Y    = mk(0,0,0,0,1,3'b001, 32'h9,   32'h9,   32'h0,  4'd4, 4'd5, 4'd0);
    Z    = mk(0,0,0,0,1,3'b001, 32'h1,   32'h2,   32'h0,  4'd1, 4'd1, 4'd0);
    L2   = mk(1,1,0,1,0,3'b000, 32'h0,   32'h0,   32'h8,  4'd3, 4'd3, 4'd7);
    V    = mk(1,0,1,1,0,3'b101, 32'haa,  32'hbb,  32'hcc, 4'd1, 4'd7, 4'd8);
    L3   = mk(1,1,0,1,0,3'b000, 32'h0,   32'h0,   32'h0,  4'd0, 4'd0, 4'd9);
    U    = mk(1,0,0,0,0,3'b000, 32'h33,  32'h44,  32'h0,  4'd9, 4'd1, 4'd10);

    rst = 1'b0;
    {reg_write_d, mem_to_reg_d, mem_write_d, alu_src_d, flags_write_d} = '0;
    alu_control_d = '0; rd1_d = '0; rd2_d = '0; ext_imm_d = '0;
    ra1_d = '0; ra2_d = '0; wa3_d = '0; flush_e = 1'b0;
    wa3_m = '0; wa3_w = '0; reg_write_m = 1'b0; reg_write_w = 1'b0; alu_flags_e = '0;
    @(posedge clk);
    #1;

    // Reset held with random inputs
    step(0, rnd_dec(), 1'($urandom), 4'($urandom), 1, 4'($urandom), 1, 4'($urandom),
         ex(E0, 4'b0000, 2'b00, 2'b00, 0));
    step(0, rnd_dec(), 1'($urandom), 4'($urandom), 1, 4'($urandom), 1, 4'($urandom),
         ex(E0, 4'b0000, 2'b00, 2'b00, 0));
    // Normal pass, then load-use on r2
    step(1, ADD,  0, 4'd0, 0, 4'd0, 0, 4'h0, ex(E0,       4'b0000, 2'b00, 2'b00, 0));
    step(1, LDR,  0, 4'd0, 0, 4'd0, 0, 4'h0, ex(ld(ADD),  4'b0000, 2'b00, 2'b00, 0));
    step(1, ADD2, 0, 4'd0, 0, 4'd0, 0, 4'h0, ex(ld(LDR),  4'b0000, 2'b00, 2'b00, 1));
    step(1, ADD2, 0, 4'd0, 0, 4'd0, 0, 4'h0, ex(E0,       4'b0000, 2'b00, 2'b00, 0));
    // Forwarding priority M over W, then W alone
    step(1, X,    0, 4'd0, 0, 4'd0, 0, 4'h0, ex(ld(ADD2), 4'b0000, 2'b00, 2'b00, 0));
    step(1, Y,    0, 4'd4, 1, 4'd4, 1, 4'h0, ex(ld(X),    4'b0000, 2'b10, 2'b00, 0));
    // CMP in E writes 0110; flushed CMP following it must not write 1000
    step(1, Z,    1, 4'd4, 0, 4'd4, 1, 4'h6, ex(ld(Y),    4'b0000, 2'b01, 2'b00, 0));
    step(1, L2,   0, 4'd0, 1, 4'd0, 1, 4'h8, ex(E0,       4'b0110, 2'b00, 2'b00, 0));
    // Flush and load-use hazard together
    step(1, V,    1, 4'd0, 0, 4'd0, 0, 4'hf, ex(ld(L2),   4'b0110, 2'b00, 2'b00, 1));
    step(1, V,    0, 4'd0, 0, 4'd0, 0, 4'hf, ex(E0,       4'b0110, 2'b00, 2'b00, 0));
    step(1, L3,   0, 4'd0, 0, 4'd0, 0, 4'h0, ex(ld(V),    4'b0110, 2'b00, 2'b00, 0));
    // Reset asserted while a load-use stall would be active
    step(0, U,    0, 4'd0, 0, 4'd0, 0, 4'h0, ex(E0,       4'b0000, 2'b00, 2'b00, 0));
    step(1, U,    0, 4'd0, 0, 4'd0, 0, 4'h0, ex(E0,       4'b0000, 2'b00, 2'b00, 0));
    step(1, ADD,  0, 4'd9, 1, 4'd1, 1, 4'h0, ex(ld(U),    4'b0000, 2'b10, 2'b01, 0));

    wait_cyc = 0;
    while (sb_q.size() > 0 && wait_cyc < 10) begin
      @(posedge clk);
      wait_cyc++;
    end
    if (sb_q.size() > 0) begin
      n_checks++;
      n_fail++;
      $display("FAIL drain: got %0d pending entries required 0", sb_q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
